// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: zig-zag scan table, code-byte layout and decoder FSM states.
package jpeg_pkg;
  localparam int BLOCK_N      = 64;
  localparam int CODE_W       = 8;
  localparam int VALUE_W      = 7;
  localparam int RUN_FLAG_BIT = 7;
  localparam int MAT_W        = BLOCK_N * CODE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DONE
  } state_t;

  // Zig-zag index k -> row-major position within the 8x8 block.
  localparam logic [5:0] ZIGZAG [BLOCK_N] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/zigzag_lut.sv
// Combinational zig-zag lookup: coefficient index k -> row-major position.
module zigzag_lut
  import jpeg_pkg::*;
(
  input  logic [5:0] k,
  output logic [5:0] pos
);

  assign pos = ZIGZAG[k];

endmodule

// File: rtl/rle_zigzag_decode.sv
// Run-length + zig-zag decoder: expands 64 code bytes into an 8x8 row-major block, one coefficient per clock.
// Optional macro RLE_DEC_ERR_EN adds the err port and malformed-stream detection.
module rle_zigzag_decode
  import jpeg_pkg::*;
(
  input  logic             Clock,
  input  logic             reset,
  input  logic             Enable,
  input  logic [MAT_W-1:0] C,
  output logic [MAT_W-1:0] A,
  output logic             done
`ifdef RLE_DEC_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [6:0] P_END = 7'd64;

  state_t             state_q, state_d;
  logic [MAT_W-1:0]   code_buf_q;
  logic [MAT_W-1:0]   work_q;
  logic [6:0]         k_q, p_q, rem_q;
  logic [6:0]         p_d, rem_d;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  wr_val;
  logic [5:0]         pos;
`ifdef RLE_DEC_ERR_EN
  logic               malformed;
  logic               err_q;
`endif

  zigzag_lut u_lut (
    .k   (k_q[5:0]),
    .pos (pos)
  );

  assign code = code_buf_q[{p_q[5:0], 3'b000} +: CODE_W];
  assign done = (state_q == ST_DONE);
`ifdef RLE_DEC_ERR_EN
  assign err  = err_q;
`endif

  always_ff @(posedge Clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Enable) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!Enable)      state_d = ST_IDLE;
        else if (k_q[6])  state_d = ST_DONE;
      end
      ST_DONE:   if (!Enable) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-coefficient decode step: a pending run takes priority over the next code byte.
  always_comb begin
    wr_val = '0;
    p_d    = p_q;
    rem_d  = rem_q;
`ifdef RLE_DEC_ERR_EN
    malformed = 1'b0;
`endif
    if (rem_q != 7'd0) begin
      rem_d = rem_q - 7'd1;
      if (rem_q == 7'd1) p_d = p_q + 7'd1;
    end else if (p_q == P_END) begin
`ifdef RLE_DEC_ERR_EN
      malformed = 1'b1;
`endif
    end else if (!code[RUN_FLAG_BIT]) begin
      wr_val = {1'b0, code[VALUE_W-1:0]};
      p_d    = p_q + 7'd1;
    end else if (code[VALUE_W-1:0] <= 7'd1) begin
      // Zero-length runs decode as a single zero.
      p_d = p_q + 7'd1;
`ifdef RLE_DEC_ERR_EN
      malformed = (code[VALUE_W-1:0] == 7'd0);
`endif
    end else begin
      rem_d = code[VALUE_W-1:0] - 7'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      code_buf_q <= '0;
      work_q     <= '0;
      A          <= '0;
      k_q        <= '0;
      p_q        <= '0;
      rem_q      <= '0;
`ifdef RLE_DEC_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (Enable) begin
          code_buf_q <= C;
          work_q     <= '0;
          k_q        <= '0;
          p_q        <= '0;
          rem_q      <= '0;
`ifdef RLE_DEC_ERR_EN
          err_q      <= 1'b0;
`endif
        end
        ST_DECODE: if (Enable) begin
          if (!k_q[6]) begin
            work_q[{pos, 3'b000} +: CODE_W] <= wr_val;
            k_q   <= k_q + 7'd1;
            p_q   <= p_d;
            rem_q <= rem_d;
`ifdef RLE_DEC_ERR_EN
            if (malformed) err_q <= 1'b1;
`endif
          end else begin
            // Publish the whole block at once; leftover run length means the run overshot.
            A <= work_q;
`ifdef RLE_DEC_ERR_EN
            if (rem_q != 7'd0) err_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_zigzag_decode.sv
// Self-checking bench for rle_zigzag_decode: directed test-plan blocks, abort/reset cases and random streams.
module tb_rle_zigzag_decode;

  logic         Clock = 1'b0;
  logic         reset;
  logic         Enable;
  logic [511:0] C;
  logic [511:0] A;
  logic         done;
`ifdef RLE_DEC_ERR_EN
  logic         err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [511:0] last_a;

  int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  always #5 Clock = ~Clock;

  rle_zigzag_decode dut (
    .Clock  (Clock),
    .reset  (reset),
    .Enable (Enable),
    .C      (C),
    .A      (A),
    .done   (done)
`ifdef RLE_DEC_ERR_EN
    ,
    .err    (err)
`endif
  );

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: expand codes into a zig-zag coefficient list, then scatter to row-major.
  function automatic void model(input logic [511:0] c, output logic [511:0] a, output bit e);
    logic [7:0] q[$];
    logic [7:0] b;
    int len;
    e = 1'b0;
    for (int n = 0; n < 64 && q.size() < 64; n++) begin
      b = c[n*8 +: 8];
      if (!b[7]) q.push_back(b);
      else begin
        len = int'(b[6:0]);
        if (len == 0) begin len = 1; e = 1'b1; end
        repeat (len) q.push_back(8'h00);
      end
    end
    while (q.size() < 64) begin q.push_back(8'h00); e = 1'b1; end
    if (q.size() > 64) e = 1'b1;
    a = '0;
    for (int k = 0; k < 64; k++) a[ZZ[k]*8 +: 8] = q[k];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] rand_stream();
    logic [511:0] v;
    int r;
    for (int n = 0; n < 64; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      v[n*8 +: 8] = {1'b0, 7'($urandom_range(0, 127))};
      else if (r < 9) v[n*8 +: 8] = {1'b1, 7'($urandom_range(1, 6))};
      else            v[n*8 +: 8] = {1'b1, 7'($urandom_range(0, 70))};
    end
    return v;
  endfunction

  task automatic decode_block(input string name, input logic [511:0] c, input bit exp_err_dir, input bit use_dir);
    logic [511:0] ea;
    bit ee;
    int cyc;
    model(c, ea, ee);
    if (use_dir) ee = exp_err_dir;
    @(negedge Clock);
    C = c;
    Enable = 1'b1;
    cyc = 0;
    do begin
      @(posedge Clock);
      #1;
      cyc++;
      if (cyc == 1) C = rand512();
    end while (!done && cyc < 200);
    check({name, " latency"}, 512'(cyc - 1), 512'(65));
    check({name, " A"}, A, ea);
`ifdef RLE_DEC_ERR_EN
    check({name, " err"}, 512'(err), 512'(ee));
`endif
    repeat (3) @(posedge Clock);
    #1;
    check({name, " hold A"}, A, ea);
    check({name, " hold done"}, 512'(done), 512'(1));
    @(negedge Clock);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check({name, " exit done"}, 512'(done), 512'(0));
    check({name, " exit A"}, A, ea);
    last_a = ea;
  endtask

  initial begin
    logic [511:0] c;
    reset  = 1'b1;
    Enable = 1'b0;
    C      = '0;
    last_a = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset A", A, '0);
    check("reset done", 512'(done), 512'(0));
`ifdef RLE_DEC_ERR_EN
    check("reset err", 512'(err), 512'(0));
`endif
    @(negedge Clock);
    reset = 1'b0;

    for (int n = 0; n < 64; n++) c[n*8 +: 8] = 8'(n + 1);
    decode_block("literals", c, 1'b0, 1'b1);

    for (int n = 0; n < 64; n++) c[n*8 +: 8] = 8'h7F;
    c[7:0] = 8'hC0;
    decode_block("allzero", c, 1'b0, 1'b1);

    c = rand512();
    c[7:0] = 8'h05; c[15:8] = 8'hBF;
    decode_block("dc5run63", c, 1'b0, 1'b1);

    c = rand512();
    c[7:0] = 8'h0A; c[15:8] = 8'hC0;
    decode_block("overshoot", c, 1'b1, 1'b1);

    c = rand512();
    c[7:0] = 8'h80; c[15:8] = 8'h03; c[23:16] = 8'hBE;
    decode_block("malformed", c, 1'b1, 1'b1);

    // Abort: Enable dropped at decode cycle 20 keeps the previous block.
    @(negedge Clock);
    C = rand_stream();
    Enable = 1'b1;
    repeat (21) @(negedge Clock);
    Enable = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("abort done", 512'(done), 512'(0));
    check("abort A", A, last_a);
    decode_block("after abort", rand_stream(), 1'b0, 1'b0);

    // Reset at decode cycle 30 with Enable still high: reset wins.
    @(negedge Clock);
    C = rand_stream();
    Enable = 1'b1;
    repeat (31) @(negedge Clock);
    reset = 1'b1;
    @(posedge Clock);
    #1;
    check("midreset A", A, '0);
    check("midreset done", 512'(done), 512'(0));
    @(negedge Clock);
    reset  = 1'b0;
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check("postreset done", 512'(done), 512'(0));
    decode_block("after reset", rand_stream(), 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) decode_block($sformatf("rand%0d", t), rand_stream(), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
